// File: rtl/vpac_pkg.sv
// rtl/vpac_pkg.sv - shared types and arithmetic helpers for the VPAC lock controller
// Purpose: FSM state encoding, default widths, modulo-difference-to-signed
//          conversion and a saturating adder reused by loop-filter blocks.
// Ports:   none (package).
package vpac_pkg;

  localparam int W_RVK_D = 7;
  localparam int W_PHE_D = 12;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PRIME  = 3'd1,
    ST_TRACK  = 3'd2,
    ST_LOCKED = 3'd3,
    ST_RESYNC = 3'd4
  } state_t;

  // Reinterpret the low w bits of a modulo difference as two's complement,
  // sign-extended to 32 bits.
  function automatic logic signed [31:0] mod_to_signed(input logic [31:0] diff,
                                                       input int          w);
    logic [31:0] mask;
    logic [31:0] m;
    mask = (32'd1 << w) - 32'd1;
    m    = diff & mask;
    if (((m >> (w - 1)) & 32'd1) != 32'd0) m = m | ~mask;
    return signed'(m);
  endfunction

  // Signed add clamped to the range of a w-bit two's complement word.
  function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                 input logic signed [31:0] b,
                                                 input int                 w);
    logic signed [32:0] s;
    logic signed [32:0] hi;
    logic signed [32:0] lo;
    s  = 33'(a) + 33'(b);
    hi = (33'sd1 <<< (w - 1)) - 33'sd1;
    lo = -(33'sd1 <<< (w - 1));
    if (s > hi) s = hi;
    else if (s < lo) s = lo;
    return 32'(s);
  endfunction

endpackage

// File: rtl/vpac_phe_acc.sv
// rtl/vpac_phe_acc.sv - RVK differentiator, per-cycle error and saturating phase accumulator
// Purpose: turns successive accumulator samples into a signed per-cycle error
//          against the integer FCW and integrates it into a saturating PHE.
// Ports:   ckr/nrst clock and async active-low reset; smp loads rvk_prev;
//          clr zeroes PHE; upd accumulates this cycle's error; fcw/rvk inputs;
//          phe/phe_vld registered result; in_tol combinational tolerance flag.
module vpac_phe_acc
  import vpac_pkg::*;
#(
  parameter int W_RVK = W_RVK_D,
  parameter int W_PHE = W_PHE_D,
  parameter int TOL   = 2
) (
  input  logic                    ckr,
  input  logic                    nrst,
  input  logic                    smp,
  input  logic                    clr,
  input  logic                    upd,
  input  logic [W_RVK-1:0]        fcw,
  input  logic [W_RVK-1:0]        rvk,
  output logic signed [W_PHE-1:0] phe,
  output logic                    phe_vld,
  output logic                    in_tol
);

  logic [W_RVK-1:0]   rvk_prev;
  logic [W_RVK-1:0]   diff;
  logic signed [31:0] err;
  logic signed [31:0] phe_sum;

  // Rollover of the accumulator is absorbed by the modulo subtraction.
  assign diff    = rvk - rvk_prev - fcw;
  assign err     = mod_to_signed(32'(diff), W_RVK);
  assign in_tol  = (err <= TOL) && (err >= -TOL);
  assign phe_sum = sat_add(32'(phe), err, W_PHE);

  always_ff @(posedge ckr or negedge nrst) begin
    if (!nrst) begin
      rvk_prev <= '0;
      phe      <= '0;
      phe_vld  <= 1'b0;
    end else begin
      phe_vld <= 1'b0;
      if (smp) rvk_prev <= rvk;
      if (clr) begin
        phe <= '0;
      end else if (upd) begin
        phe     <= W_PHE'(phe_sum);
        phe_vld <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/vpac_lock_ctrl.sv
// rtl/vpac_lock_ctrl.sv - CKR-domain sequencer and lock detector for the variable-phase accumulator
// Purpose: holds the VPAC in reset while disabled, primes the sample pipeline,
//          tracks phase error and declares lock / loss-of-lock with resync.
// Ports:   CKR clock; NRST async active-low reset; EN enable; FCW_I integer FCW;
//          RVK sampled accumulator word; VPAC_NRST accumulator reset; PHE/PHE_VLD
//          accumulated phase error and its strobe; LOCK indicator; STATE debug code.
module vpac_lock_ctrl
  import vpac_pkg::*;
#(
  parameter int W_RVK     = W_RVK_D,
  parameter int W_PHE     = W_PHE_D,
  parameter int TOL       = 2,
  parameter int LOCK_CNT  = 16,
  parameter int LOL_CNT   = 4,
  parameter int PRIME_CYC = 3
) (
  input  logic                    CKR,
  input  logic                    NRST,
  input  logic                    EN,
  input  logic [W_RVK-1:0]        FCW_I,
  input  logic [W_RVK-1:0]        RVK,
  output logic                    VPAC_NRST,
  output logic signed [W_PHE-1:0] PHE,
  output logic                    PHE_VLD,
  output logic                    LOCK,
  output logic [2:0]              STATE
);

  localparam int PW = $clog2(PRIME_CYC + 1);
  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam int BW = $clog2(LOL_CNT + 1);

  state_t        state, state_n;
  logic [PW-1:0] prime_cnt, prime_n;
  logic [GW-1:0] good_cnt, good_n;
  logic [BW-1:0] bad_cnt, bad_n;
  logic          lock, lock_n;
  logic          vpac_nrst, vpac_n;
  logic          in_tol;
  logic          smp, clr, upd;

  // Datapath controls follow the current state; EN low freezes PHE.
  assign smp = EN && (state == ST_PRIME || state == ST_TRACK || state == ST_LOCKED);
  assign clr = EN && (state == ST_PRIME);
  assign upd = EN && (state == ST_TRACK || state == ST_LOCKED);

  vpac_phe_acc #(
    .W_RVK (W_RVK),
    .W_PHE (W_PHE),
    .TOL   (TOL)
  ) u_phe_acc (
    .ckr     (CKR),
    .nrst    (NRST),
    .smp     (smp),
    .clr     (clr),
    .upd     (upd),
    .fcw     (FCW_I),
    .rvk     (RVK),
    .phe     (PHE),
    .phe_vld (PHE_VLD),
    .in_tol  (in_tol)
  );

  always_ff @(posedge CKR or negedge NRST) begin
    if (!NRST) begin
      state     <= ST_IDLE;
      prime_cnt <= '0;
      good_cnt  <= '0;
      bad_cnt   <= '0;
      lock      <= 1'b0;
      vpac_nrst <= 1'b0;
    end else begin
      state     <= state_n;
      prime_cnt <= prime_n;
      good_cnt  <= good_n;
      bad_cnt   <= bad_n;
      lock      <= lock_n;
      vpac_nrst <= vpac_n;
    end
  end

  always_comb begin
    state_n = state;
    prime_n = prime_cnt;
    good_n  = good_cnt;
    bad_n   = bad_cnt;
    lock_n  = lock;
    vpac_n  = vpac_nrst;
    // EN low wins over any lock / loss-of-lock decision this cycle.
    if (!EN) begin
      state_n = ST_IDLE;
      prime_n = '0;
      good_n  = '0;
      bad_n   = '0;
      lock_n  = 1'b0;
      vpac_n  = 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          state_n = ST_PRIME;
          prime_n = '0;
          vpac_n  = 1'b1;
        end
        ST_PRIME: begin
          vpac_n = 1'b1;
          if (prime_cnt == PW'(PRIME_CYC - 1)) begin
            state_n = ST_TRACK;
            prime_n = '0;
            good_n  = '0;
          end else begin
            prime_n = prime_cnt + PW'(1);
          end
        end
        ST_TRACK: begin
          if (!in_tol) begin
            good_n = '0;
          end else if (good_cnt == GW'(LOCK_CNT - 1)) begin
            state_n = ST_LOCKED;
            good_n  = GW'(LOCK_CNT);
            bad_n   = '0;
            lock_n  = 1'b1;
          end else begin
            good_n = good_cnt + GW'(1);
          end
        end
        ST_LOCKED: begin
          if (in_tol) begin
            bad_n = '0;
          end else if (bad_cnt == BW'(LOL_CNT - 1)) begin
            state_n = ST_RESYNC;
            bad_n   = BW'(LOL_CNT);
            lock_n  = 1'b0;
            vpac_n  = 1'b0;
          end else begin
            bad_n = bad_cnt + BW'(1);
          end
        end
        ST_RESYNC: begin
          state_n = ST_PRIME;
          prime_n = '0;
          vpac_n  = 1'b1;
        end
        default: begin
          state_n = ST_IDLE;
          lock_n  = 1'b0;
          vpac_n  = 1'b0;
        end
      endcase
    end
  end

  assign VPAC_NRST = vpac_nrst;
  assign LOCK      = lock;
  assign STATE     = state;

endmodule

// File: tb/tb_vpac_lock_ctrl.sv
// tb/tb_vpac_lock_ctrl.sv - directed self-checking bench for vpac_lock_ctrl
module tb_vpac_lock_ctrl;

  logic               CKR;
  logic               NRST;
  logic               EN;
  logic [6:0]         FCW_I;
  logic [6:0]         RVK;
  logic               VPAC_NRST;
  logic signed [11:0] PHE;
  logic               PHE_VLD;
  logic               LOCK;
  logic [2:0]         STATE;

  int n_tests;
  int n_fail;

  vpac_lock_ctrl dut (
    .CKR       (CKR),
    .NRST      (NRST),
    .EN        (EN),
    .FCW_I     (FCW_I),
    .RVK       (RVK),
    .VPAC_NRST (VPAC_NRST),
    .PHE       (PHE),
    .PHE_VLD   (PHE_VLD),
    .LOCK      (LOCK),
    .STATE     (STATE)
  );

  initial CKR = 1'b0;
  always #5 CKR = ~CKR;

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance RVK by step, then let one CKR edge pass and settle.
  task automatic cyc(input int step);
    RVK = RVK + 7'(step);
    @(posedge CKR);
    #1;
  endtask

  initial begin
    int exp_phe;
    n_tests = 0;
    n_fail  = 0;
    NRST  = 1'b1;
    EN    = 1'b0;
    FCW_I = 7'd40;
    RVK   = 7'd0;
    #1 NRST = 1'b0;
    cyc(0);
    cyc(0);
    chk("rst_state", int'(STATE), 0);
    chk("rst_vpac", int'(VPAC_NRST), 0);
    chk("rst_phe", int'(PHE), 0);
    chk("rst_vld", int'(PHE_VLD), 0);
    chk("rst_lock", int'(LOCK), 0);
    NRST = 1'b1;
    cyc(0);
    chk("idle_hold", int'(STATE), 0);

    // Basic lock: FCW 40, RVK +40 per cycle.
    EN = 1'b1;
    cyc(40);
    chk("prime_enter", int'(STATE), 1);
    chk("vpac_rise", int'(VPAC_NRST), 1);
    cyc(40);
    chk("prime_2", int'(STATE), 1);
    cyc(40);
    chk("prime_3", int'(STATE), 1);
    cyc(40);
    chk("track_enter", int'(STATE), 2);
    for (int i = 0; i < 15; i++) cyc(40);
    chk("track_15_state", int'(STATE), 2);
    chk("track_15_lock", int'(LOCK), 0);
    chk("track_phe", int'(PHE), 0);
    chk("track_vld", int'(PHE_VLD), 1);
    cyc(40);
    chk("lock_state", int'(STATE), 3);
    chk("lock_flag", int'(LOCK), 1);
    chk("lock_phe", int'(PHE), 0);

    // Wrap: reach RVK=80 then 120 -> 32 -> 72.
    for (int i = 0; i < 16 && RVK != 7'd80; i++) cyc(40);
    chk("wrap_setup", int'(RVK), 80);
    cyc(40);
    chk("wrap_120_phe", int'(PHE), 0);
    cyc(40);
    chk("wrap_32_phe", int'(PHE), 0);
    chk("wrap_32_lock", int'(LOCK), 1);
    cyc(40);
    chk("wrap_72_phe", int'(PHE), 0);
    chk("wrap_72_state", int'(STATE), 3);

    // Loss of lock: four steps of +44, err = +4 each.
    for (int i = 1; i <= 4; i++) begin
      cyc(44);
      chk("lol_phe", int'(PHE), 4 * i);
      if (i < 4) chk("lol_still_locked", int'(LOCK), 1);
    end
    chk("lol_state", int'(STATE), 4);
    chk("lol_lock", int'(LOCK), 0);
    chk("lol_vpac", int'(VPAC_NRST), 0);
    cyc(42);
    chk("resync_to_prime", int'(STATE), 1);
    chk("resync_vpac", int'(VPAC_NRST), 1);
    chk("resync_vld", int'(PHE_VLD), 0);
    chk("resync_phe_hold", int'(PHE), 16);
    cyc(42);
    chk("reprime_clear", int'(PHE), 0);
    cyc(42);
    cyc(42);
    chk("reprime_track", int'(STATE), 2);

    // Tolerance edge +42: err = +2 each cycle, still locks.
    for (int i = 0; i < 15; i++) cyc(42);
    chk("tol_p2_15", int'(STATE), 2);
    cyc(42);
    chk("tol_p2_state", int'(STATE), 3);
    chk("tol_p2_phe", int'(PHE), 32);

    // EN drop from LOCKED, then +38: err = -2 each cycle.
    EN = 1'b0;
    cyc(38);
    chk("en_off_state", int'(STATE), 0);
    chk("en_off_lock", int'(LOCK), 0);
    chk("en_off_phe", int'(PHE), 32);
    EN = 1'b1;
    for (int i = 0; i < 4; i++) cyc(38);
    chk("tol_m2_track", int'(STATE), 2);
    for (int i = 0; i < 16; i++) cyc(38);
    chk("tol_m2_state", int'(STATE), 3);
    chk("tol_m2_phe", int'(PHE), -32);

    // +43: err = +3, outside tolerance, never locks.
    EN = 1'b0;
    cyc(43);
    EN = 1'b1;
    for (int i = 0; i < 4; i++) cyc(43);
    for (int i = 0; i < 20; i++) cyc(43);
    chk("tol_p3_state", int'(STATE), 2);
    chk("tol_p3_lock", int'(LOCK), 0);
    chk("tol_p3_phe", int'(PHE), 60);

    // Abort from TRACK.
    EN = 1'b0;
    cyc(43);
    chk("abort_state", int'(STATE), 0);
    chk("abort_vpac", int'(VPAC_NRST), 0);
    chk("abort_vld", int'(PHE_VLD), 0);
    chk("abort_phe", int'(PHE), 60);

    // Saturation: FCW 0, RVK +63, err = +63 each cycle.
    FCW_I = 7'd0;
    EN = 1'b1;
    for (int i = 0; i < 4; i++) cyc(63);
    chk("sat_track", int'(STATE), 2);
    chk("sat_start", int'(PHE), 0);
    for (int k = 1; k <= 70; k++) begin
      cyc(63);
      exp_phe = (63 * k > 2047) ? 2047 : 63 * k;
      chk("sat_phe", int'(PHE), exp_phe);
    end

    // Async reset while LOCKED.
    EN = 1'b0;
    cyc(0);
    FCW_I = 7'd40;
    EN = 1'b1;
    for (int i = 0; i < 20; i++) cyc(40);
    chk("relock_state", int'(STATE), 3);
    cyc(41);
    cyc(41);
    chk("relock_phe", int'(PHE), 2);
    chk("relock_lock", int'(LOCK), 1);
    #2 NRST = 1'b0;
    #1;
    chk("async_state", int'(STATE), 0);
    chk("async_vpac", int'(VPAC_NRST), 0);
    chk("async_lock", int'(LOCK), 0);
    chk("async_phe", int'(PHE), 0);
    NRST = 1'b1;
    cyc(40);
    chk("post_rst_prime", int'(STATE), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
